// File: rtl/fibo_ctrl.sv
// fibo_ctrl: sequences F(n) mod 16 through an external 4-bit ALU, adds and loop decrements alike.
// a/b hold consecutive Fibonacci residues; ova/ovb tag whether the true value has exceeded 15.
module fibo_ctrl #(
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_SUB = 3'b001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] n,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_d,
    input  logic       alu_zero,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       overflow
);
    typedef enum logic [2:0] {IDLE, ZCHK, ADD, DEC, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] a, b, cnt, a_nx, b_nx, cnt_nx;
    logic [3:0] alu_a_nx, alu_b_nx, result_nx;
    logic [2:0] op_nx;
    logic       ova, ovb, ova_nx, ovb_nx, overflow_nx;

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        state_nx    = state;
        a_nx        = a;
        b_nx        = b;
        cnt_nx      = cnt;
        ova_nx      = ova;
        ovb_nx      = ovb;
        alu_a_nx    = 4'd0;
        alu_b_nx    = 4'd0;
        op_nx       = OP_ADD;
        result_nx   = result;
        overflow_nx = overflow;
        case (state)
            IDLE: if (start) begin
                a_nx     = 4'd0;
                b_nx     = 4'd1;
                cnt_nx   = n;
                ova_nx   = 1'b0;
                ovb_nx   = 1'b0;
                alu_a_nx = n;
                state_nx = ZCHK;
            end
            ZCHK: if (alu_zero) state_nx = DONE;
            else begin
                alu_a_nx = a;
                alu_b_nx = b;
                state_nx = ADD;
            end
            ADD: begin
                a_nx     = b;
                b_nx     = alu_d;
                ova_nx   = ovb;
                // with residues in 0..15 the sum wrapped exactly when it came out below an addend
                ovb_nx   = ovb | (alu_d < b);
                alu_a_nx = cnt;
                alu_b_nx = 4'd1;
                op_nx    = OP_SUB;
                state_nx = DEC;
            end
            DEC: begin
                cnt_nx = alu_d;
                if (alu_zero) state_nx = DONE;
                else begin
                    alu_a_nx = a;
                    alu_b_nx = b;
                    state_nx = ADD;
                end
            end
            DONE: begin
                result_nx   = a;
                overflow_nx = ova;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= 4'd0;
            b          <= 4'd0;
            cnt        <= 4'd0;
            ova        <= 1'b0;
            ovb        <= 1'b0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_opcode <= OP_ADD;
            result     <= 4'd0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            a          <= a_nx;
            b          <= b_nx;
            cnt        <= cnt_nx;
            ova        <= ova_nx;
            ovb        <= ovb_nx;
            alu_a      <= alu_a_nx;
            alu_b      <= alu_b_nx;
            alu_opcode <= op_nx;
            result     <= result_nx;
            overflow   <= overflow_nx;
        end
    end
endmodule
